// File: rtl/anc_lms_update.sv
// LMS coefficient updater for the ANC FIR filter: captures one reference/error
// sample pair per Synch rise, shifts the reference delay line and streams every adapted weight.
module anc_lms_update #(
    parameter int TAPS      = 8,
    parameter int TAPS_LOG2 = 3,
    parameter int MU_SHIFT  = 4
) (
    input  logic                 Clk_100M,
    input  logic                 Reset,
    input  logic                 UpdateEN,
    input  logic                 Synch,
    input  logic signed [10:0]   RefIn,
    input  logic signed [10:0]   ErrIn,
    output logic signed [10:0]   WzOut,
    output logic [TAPS_LOG2-1:0] WzIdx,
    output logic                 WzValid,
    output logic                 Busy,
    output logic                 Overrun
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPD
    } state_t;

    localparam logic [TAPS_LOG2-1:0] LAST_IDX = TAPS_LOG2'(TAPS - 1);

    state_t                state;
    logic                  synch_d;
    logic                  sample_edge;
    logic signed [10:0]    xr;
    logic signed [10:0]    er;
    logic signed [10:0]    x_line [TAPS];
    logic signed [10:0]    w      [TAPS];
    logic [TAPS_LOG2-1:0]  idx;

    logic signed [21:0]    prod;
    logic signed [21:0]    delta;
    logic signed [22:0]    sum;
    logic signed [10:0]    sat;

    assign sample_edge = Synch & ~synch_d;
    assign Busy        = (state != IDLE);

    // One tap of the LMS datapath; the 23-bit sum cannot overflow before clamping.
    always_comb begin
        prod  = 22'(er) * 22'(x_line[idx]);
        delta = prod >>> MU_SHIFT;
        sum   = 23'(w[idx]) + 23'(delta);
        sat   = sum[10:0];
        if (sum > 23'sd1023) begin
            sat = 11'sd1023;
        end else if (sum < -23'sd1024) begin
            sat = -11'sd1024;
        end
    end

    always_ff @(posedge Clk_100M or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            synch_d <= 1'b0;
            xr      <= '0;
            er      <= '0;
            idx     <= '0;
            WzOut   <= '0;
            WzIdx   <= '0;
            WzValid <= 1'b0;
            Overrun <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                x_line[k] <= '0;
                w[k]      <= '0;
            end
        end else begin
            synch_d <= Synch;
            WzValid <= 1'b0;
            // Any sample edge that finds the sequencer busy is dropped, including the return cycle.
            if (sample_edge && state != IDLE) begin
                Overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sample_edge) begin
                        xr    <= RefIn;
                        er    <= ErrIn;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    for (int k = TAPS - 1; k > 0; k--) begin
                        x_line[k] <= x_line[k-1];
                    end
                    x_line[0] <= xr;
                    idx       <= '0;
                    state     <= UPD;
                end
                UPD: begin
                    if (UpdateEN) begin
                        w[idx] <= sat;
                        WzOut  <= sat;
                    end else begin
                        WzOut  <= w[idx];
                    end
                    WzIdx   <= idx;
                    WzValid <= 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= IDLE;
                    end else begin
                        idx <= idx + TAPS_LOG2'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
